// File: rtl/alu_out_stage.sv
// EX-stage output skid buffer (2 entries) with signed-overflow trap drop and sticky exception.
// Optional ALU_OUT_STATS_EN adds saturating zero_cnt/trap_cnt counters.
module alu_out_stage #(
  parameter int WIDTH  = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_S,
  input  logic              in_Z,
  input  logic              in_V,
  input  logic              in_N,
  input  logic              in_trap,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_S,
  output logic              out_Z,
  output logic              out_V,
  output logic              out_N,
  output logic [DEST_W-1:0] out_dest,
  output logic              exc_ovf,
  output logic [DEST_W-1:0] exc_dest,
  input  logic              exc_ack
`ifdef ALU_OUT_STATS_EN
  ,
  output logic [15:0]       zero_cnt,
  output logic [15:0]       trap_cnt
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0]  s;
    logic              z;
    logic              v;
    logic              n;
    logic [DEST_W-1:0] dest;
  } entry_t;

  entry_t     head, tail, in_entry;
  logic [1:0] count;
  logic       push, pop, trap_drop, store;

  // in_ready depends only on state (and reset), never on out_ready.
  assign in_ready  = ~reset & (count != 2'd2) & ~exc_ovf;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign trap_drop = push & in_trap & in_V;
  assign store     = push & ~trap_drop;

  assign in_entry = '{s: in_S, z: in_Z, v: in_V, n: in_N, dest: in_dest};

  assign out_S    = head.s;
  assign out_Z    = head.z;
  assign out_V    = head.v;
  assign out_N    = head.n;
  assign out_dest = head.dest;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (store) begin
            head  <= in_entry;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (store && pop) begin
            head <= in_entry;
          end else if (store) begin
            tail  <= in_entry;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head  <= tail;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

  // A trap drop cannot coincide with a pending exception since pushes are blocked then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_ovf  <= 1'b0;
      exc_dest <= '0;
    end else if (trap_drop) begin
      exc_ovf  <= 1'b1;
      exc_dest <= in_dest;
    end else if (exc_ack) begin
      exc_ovf  <= 1'b0;
    end
  end

`ifdef ALU_OUT_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_cnt <= 16'd0;
      trap_cnt <= 16'd0;
    end else begin
      if (pop && head.z && (zero_cnt != 16'hFFFF))
        zero_cnt <= zero_cnt + 16'd1;
      if (trap_drop && (trap_cnt != 16'hFFFF))
        trap_cnt <= trap_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/alu_out_stage.md
Name: alu_out_stage

Overview:
- EX-stage output buffer directly downstream of the ALU function units (ADD/SUB/EQ/NEQ/LT/...). It captures S/Z/V/N plus destination register per operation.
- 2-entry skid buffer with valid/ready on both sides decouples the ALU from MEM-stage stalls.
- Detects signed-overflow traps: a trapping result is dropped, not forwarded, and a sticky exception is raised for the CP0 logic.

Parameters:
WIDTH, 32, datapath width of S
DEST_W, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
in_valid  in  1  ALU result valid
in_ready  out  1  stage can accept a result this cycle
in_S  in  WIDTH  ALU result
in_Z  in  1  ALU zero flag
in_V  in  1  ALU overflow flag
in_N  in  1  ALU negative flag
in_trap  in  1  op is a trapping signed op (ADD/SUB/ADDI); V means exception
in_dest  in  DEST_W  destination register
out_valid  out  1  head entry valid
out_ready  in  1  MEM stage consumes head
out_S  out  WIDTH  head result
out_Z  out  1  head zero flag
out_V  out  1  head overflow flag (always 0 for a forwarded trap op)
out_N  out  1  head negative flag
out_dest  out  DEST_W  head destination
exc_ovf  out  1  sticky overflow exception pending
exc_dest  out  DEST_W  dest of the dropped trapping op
exc_ack  in  1  CP0 acknowledges and clears exc_ovf

Behaviour:
- Reset (asynchronous, active-high): count=0, out_valid=0, out_S=0, out_Z=0, out_V=0, out_N=0, out_dest=0, exc_ovf=0, exc_dest=0. in_ready=0 while reset is high.
- States by occupancy: EMPTY(0), ONE(1), FULL(2). in_ready = (count!=2) && !exc_ovf. Registered, no combinational path from out_ready.
- push = in_valid && in_ready; pop = out_valid && out_ready; out_valid = (count!=0).
- Outputs always show head entry (entry 0). FIFO order is strictly preserved.
- Trap drop: push with in_trap && in_V does not enter the buffer. Next edge: exc_ovf<=1, exc_dest<=in_dest, count unchanged. A pop in the same cycle still proceeds.
- Non-trap push with in_V=1: stored normally, out_V=1.
- Transitions:
  - EMPTY + push -> ONE; data is visible at outputs the next cycle (latency 1).
  - ONE + push, no pop -> FULL.
  - ONE + push + pop -> ONE; new data becomes the head.
  - ONE + pop -> EMPTY.
  - FULL + pop -> ONE; entry 1 shifts to the head.
  - FULL: no push is possible.
- exc_ovf blocks all further pushes until exc_ack. Already-buffered entries still drain.
- exc_ack: clears exc_ovf next edge. in_ready re-asserts the following cycle if count<2. exc_ack with exc_ovf=0 is ignored. exc_dest holds its value until the next trap.
- in_valid without in_ready: no state change. The upstream ALU must hold its inputs.
- Reset mid-operation discards all entries and any pending exception.

Optional Feature:
ALU_OUT_STATS_EN
- Defined: adds output ports zero_cnt[15:0] and trap_cnt[15:0], both reset to 0.
  - zero_cnt increments on every pop with out_Z=1.
  - trap_cnt increments on every trap drop.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, then in_valid=1, in_S=32'h5, in_dest=3, out_ready=1 -> next cycle out_valid=1, out_S=5, out_dest=3; count returns to 0 after the pop.
- out_ready=0, push A=1, B=2 -> in_ready=0 after the 2nd push. out_ready=1 -> out_S=1 then 2, in order; in_ready=1 again after the first pop.
- ONE state with simultaneous push(7) and pop -> count stays 1, out_S=7 next cycle.
- in_trap=1, in_V=1, in_dest=9 -> exc_ovf=1, exc_dest=9, no out_valid, in_ready=0. Pulse exc_ack -> exc_ovf=0, in_ready=1 next cycle.
- in_trap=0, in_V=1, in_S=32'h80000000 -> forwarded with out_V=1, out_N as given, exc_ovf stays 0.
- Assert reset while FULL and exc_ovf=1 -> out_valid=0 and exc_ovf=0 immediately (async); with ALU_OUT_STATS_EN, both counters read 0.
